elev_ctrl: RTL and testbench

ELEV_CTRL -- requirements
Module: elev_ctrl

---
 rtl/elev_pkg.sv | 50 +++++
 rtl/elev_tick_gen.sv | 31 +++
 rtl/elev_ctrl.sv | 154 +++++++++++++++
 tb/tb_elev_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// Shared types and helpers for the elevator controller: floor geometry,
// the controller state encoding and the direction-selection rule.
package elev_pkg;

  localparam int NUM_FLOORS = 10;
  localparam int FLOOR_W    = 4;
  localparam int TIMER_W    = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } elev_state_e;

  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      m[i] = (FLOOR_W'(i) > f);
    end
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      m[i] = (FLOOR_W'(i) < f);
    end
    return m;
  endfunction

  // Calls ahead in the preferred direction win; otherwise reverse or rest.
  function automatic elev_state_e pick_dir(input logic dir_up, input logic above,
                                           input logic below);
    elev_state_e s;
    if (dir_up) begin
      if (above)      s = MOVE_UP;
      else if (below) s = MOVE_DOWN;
      else            s = IDLE;
    end else begin
      if (below)      s = MOVE_DOWN;
      else if (above) s = MOVE_UP;
      else            s = IDLE;
    end
    return s;
  endfunction

endpackage

// File: rtl/elev_tick_gen.sv
// Timing tick divider: clk_count wraps every TICK_DIV cycles and flag marks the
// wrap cycle. The controller restarts the count whenever its timing restarts.
module elev_tick_gen #(
  parameter int TICK_DIV = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic flag
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] clk_count;

  assign flag = (clk_count == CNT_W'(TICK_DIV - 1));

  // divider counter with restart
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_count <= '0;
    end else if (clr) begin
      clk_count <= '0;
    end else if (flag) begin
      clk_count <= '0;
    end else begin
      clk_count <= clk_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/elev_ctrl.sv
// Ten-floor elevator controller. Define ELEV_DEBUG_EN to mirror floor on
// current_floor_debug; otherwise that port is tied to zero.
module elev_ctrl
  import elev_pkg::*;
#(
  parameter int TICK_DIV   = 5,
  parameter int MOVE_TICKS = 2,
  parameter int DOOR_TICKS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] buttons_inside,
  input  logic [8:0] buttons_outside_up,
  input  logic [9:1] buttons_outside_down,
  output logic       up_signal,
  output logic       down_signal,
  output logic       open_door,
  output logic [3:0] floor,
  output logic [3:0] current_floor_debug
);

  elev_state_e state_r;
  elev_state_e next_state_s;
  logic [FLOOR_W-1:0]    next_floor_s;
  logic [FLOOR_W-1:0]    tgt_floor_s;
  logic [TIMER_W-1:0]    timer;
  logic [TIMER_W-1:0]    next_timer_s;
  logic [NUM_FLOORS-1:0] requests;
  logic [NUM_FLOORS-1:0] press_s;
  logic [NUM_FLOORS-1:0] pending_s;
  logic [NUM_FLOORS-1:0] clr_mask_s;
  logic dir_up_r;
  logic next_dir_s;
  logic restart_s;
  logic tick_clr_s;
  logic flag;
  logic above_s;
  logic below_s;
  logic tgt_above_s;
  logic tgt_below_s;

  elev_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .clr   (tick_clr_s),
    .flag  (flag)
  );

  // Presses are acted on in the cycle they are sampled, not a cycle later.
  assign press_s   = buttons_inside | {1'b0, buttons_outside_up} | {buttons_outside_down, 1'b0};
  assign pending_s = requests | press_s;

  // Floor reached at the end of the current hop, clamped to the shaft ends.
  assign tgt_floor_s = (state_r == MOVE_UP   && floor < FLOOR_W'(NUM_FLOORS - 1)) ? floor + FLOOR_W'(1) :
                       (state_r == MOVE_DOWN && floor > FLOOR_W'(0))              ? floor - FLOOR_W'(1) :
                       floor;

  assign above_s     = |(pending_s & above_mask(floor));
  assign below_s     = |(pending_s & below_mask(floor));
  assign tgt_above_s = |(pending_s & above_mask(tgt_floor_s));
  assign tgt_below_s = |(pending_s & below_mask(tgt_floor_s));

  // next-state, travel and door timing
  always_comb begin
    next_state_s = state_r;
    next_floor_s = floor;
    next_timer_s = timer;
    restart_s    = 1'b0;
    case (state_r)
      IDLE: begin
        next_timer_s = '0;
        if (pending_s[floor])  next_state_s = DOOR_OPEN;
        else if (above_s)      next_state_s = MOVE_UP;
        else if (below_s)      next_state_s = MOVE_DOWN;
        else                   next_state_s = IDLE;
      end
      MOVE_UP, MOVE_DOWN: begin
        if (flag) begin
          if (timer == TIMER_W'(MOVE_TICKS - 1)) begin
            next_timer_s = '0;
            next_floor_s = tgt_floor_s;
            if (pending_s[tgt_floor_s]) next_state_s = DOOR_OPEN;
            else next_state_s = pick_dir(state_r == MOVE_UP, tgt_above_s, tgt_below_s);
          end else begin
            next_timer_s = timer + TIMER_W'(1);
          end
        end else begin
          next_timer_s = timer;
        end
      end
      DOOR_OPEN: begin
        if (pending_s[floor]) begin
          restart_s    = 1'b1;
          next_timer_s = '0;
        end else if (flag) begin
          if (timer == TIMER_W'(DOOR_TICKS - 1)) begin
            next_timer_s = '0;
            next_state_s = pick_dir(dir_up_r, above_s, below_s);
          end else begin
            next_timer_s = timer + TIMER_W'(1);
          end
        end else begin
          next_timer_s = timer;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_timer_s = '0;
      end
    endcase
  end

  // direction memory, served-call mask and divider restart
  always_comb begin
    next_dir_s = dir_up_r;
    clr_mask_s = '0;
    if (next_state_s == MOVE_UP)        next_dir_s = 1'b1;
    else if (next_state_s == MOVE_DOWN) next_dir_s = 1'b0;
    else                                next_dir_s = dir_up_r;
    if (next_state_s == DOOR_OPEN) clr_mask_s = NUM_FLOORS'(1) << next_floor_s;
    else                           clr_mask_s = '0;
    tick_clr_s = (next_state_s != state_r) | restart_s;
  end

  // controller registers and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      floor       <= '0;
      timer       <= '0;
      requests    <= '0;
      dir_up_r    <= 1'b1;
      up_signal   <= 1'b0;
      down_signal <= 1'b0;
      open_door   <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      floor       <= next_floor_s;
      timer       <= (next_state_s != state_r) ? '0 : next_timer_s;
      requests    <= pending_s & ~clr_mask_s;
      dir_up_r    <= next_dir_s;
      up_signal   <= (next_state_s == MOVE_UP);
      down_signal <= (next_state_s == MOVE_DOWN);
      open_door   <= (next_state_s == DOOR_OPEN);
    end
  end

`ifdef ELEV_DEBUG_EN
  assign current_floor_debug = floor;
`else
  assign current_floor_debug = 4'd0;
`endif

endmodule

// File: tb/tb_elev_ctrl.sv
// Directed bench for elev_ctrl at default parameters (10 cycles per floor,
// 10 cycles of open door); expected timings are hand-derived.
module tb_elev_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] bi    = 10'd0;
  logic [8:0] bou   = 9'd0;
  logic [9:1] bod   = 9'd0;
  logic       up_signal;
  logic       down_signal;
  logic       open_door;
  logic [3:0] floor;
  logic [3:0] current_floor_debug;

  int checks     = 0;
  int failures   = 0;
  int door_q[$];
  int exp_q[$];
  int max_floor  = 0;
  int onehot_err = 0;
  int dbg_err    = 0;
  logic prev_open = 1'b0;

  elev_ctrl dut (
    .clock                (clock),
    .reset                (reset),
    .buttons_inside       (bi),
    .buttons_outside_up   (bou),
    .buttons_outside_down (bod),
    .up_signal            (up_signal),
    .down_signal          (down_signal),
    .open_door            (open_door),
    .floor                (floor),
    .current_floor_debug  (current_floor_debug)
  );

  always #5 clock = ~clock;

  // Door-open floor log, highest floor seen, output exclusivity, debug mirror
  always @(negedge clock) begin
    int exp_dbg;
    if (open_door && !prev_open) door_q.push_back(int'(floor));
    prev_open = open_door;
    if (int'(floor) > max_floor) max_floor = int'(floor);
    if ((int'(up_signal) + int'(down_signal) + int'(open_door)) > 1) onehot_err++;
`ifdef ELEV_DEBUG_EN
    exp_dbg = int'(floor);
`else
    exp_dbg = 0;
`endif
    if (int'(current_floor_debug) != exp_dbg) dbg_err++;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bi = 10'd0; bou = 9'd0; bod = 9'd0;
    step(2);
    reset = 1'b0;
    step(1);
    door_q.delete();
    max_floor = 0;
  endtask

  // One-cycle press; returns just after the edge that sampled it.
  task automatic press(input logic [9:0] i, input logic [8:0] u, input logic [9:1] d);
    bi = i; bou = u; bod = d;
    step(1);
    bi = 10'd0; bou = 9'd0; bod = 9'd0;
  endtask

  task automatic check_outs(input string tag, input int up, input int dn, input int op);
    check_eq(tag, int'({up_signal, down_signal, open_door}), (up << 2) | (dn << 1) | op);
  endtask

  task automatic check_doors(input string tag);
    check_eq({tag, "_n"}, door_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      check_eq($sformatf("%s_%0d", tag, i), (i < door_q.size()) ? door_q[i] : -1, exp_q[i]);
    end
  endtask

  initial begin
    step(2);
    check_outs("rst_outs", 0, 0, 0);
    check_eq("rst_floor", int'(floor), 0);
    check_eq("rst_req", int'(dut.requests), 0);

    // single request to floor 4
    do_reset();
    press(10'b0000010000, 9'd0, 9'd0);
    check_outs("a_start", 1, 0, 0);
    check_eq("a_f0", int'(floor), 0);
    step(39);
    check_eq("a_f39", int'(floor), 3);
    check_outs("a_o39", 1, 0, 0);
    step(1);
    check_eq("a_f40", int'(floor), 4);
    check_outs("a_o40", 0, 0, 1);
    step(9);
    check_outs("a_o49", 0, 0, 1);
    step(1);
    check_outs("a_o50", 0, 0, 0);
    check_eq("a_f50", int'(floor), 4);
    check_eq("a_req", int'(dut.requests), 0);

    // several upward calls
    do_reset();
    press(10'b0011101000, 9'd0, 9'd0);
    step(120);
    exp_q = '{3, 5, 6, 7};
    check_doors("b_seq");
    check_eq("b_req", int'(dut.requests), 0);
    check_outs("b_idle", 0, 0, 0);
    check_eq("b_floor", int'(floor), 7);

    // reversal after serving floor 7
    do_reset();
    press(10'b0010000000, 9'd0, 9'd0);
    step(70);
    check_eq("c_f70", int'(floor), 7);
    check_outs("c_o70", 0, 0, 1);
    step(2);
    press(10'd0, 9'd0, 9'b000000100);
    step(6);
    check_outs("c_o79", 0, 0, 1);
    step(1);
    check_outs("c_o80", 0, 1, 0);
    check_eq("c_f80", int'(floor), 7);
    step(39);
    check_eq("c_f119", int'(floor), 4);
    check_outs("c_o119", 0, 1, 0);
    step(1);
    check_eq("c_f120", int'(floor), 3);
    check_outs("c_o120", 0, 0, 1);
    step(10);
    check_outs("c_o130", 0, 0, 0);

    // same-floor call and door extension
    do_reset();
    press(10'b0000100000, 9'd0, 9'd0);
    step(60);
    check_outs("d_o60", 0, 0, 0);
    check_eq("d_f60", int'(floor), 5);
    step(5);
    press(10'd0, 9'b000100000, 9'd0);
    check_outs("d_open", 0, 0, 1);
    check_eq("d_f66", int'(floor), 5);
    step(4);
    press(10'd0, 9'b000100000, 9'd0);
    step(5);
    check_outs("d_ext76", 0, 0, 1);
    step(4);
    check_outs("d_ext80", 0, 0, 1);
    step(1);
    check_outs("d_close", 0, 0, 0);
    check_eq("d_f81", int'(floor), 5);

    // mixed calls up to the top floor
    do_reset();
    press(10'b1100010110, 9'd0, 9'd0);
    step(150);
    exp_q = '{1, 2, 4, 8, 9};
    check_doors("e_seq");
    check_eq("e_max", max_floor, 9);
    check_eq("e_req", int'(dut.requests), 0);
    check_outs("e_idle", 0, 0, 0);
    check_eq("e_floor", int'(floor), 9);

    // reset while travelling between floors 2 and 3
    do_reset();
    press(10'b1000000000, 9'd0, 9'd0);
    step(24);
    check_eq("f_f25", int'(floor), 2);
    check_outs("f_o25", 1, 0, 0);
    reset = 1'b1;
    #1;
    check_eq("f_rst_floor", int'(floor), 0);
    check_eq("f_rst_req", int'(dut.requests), 0);
    check_outs("f_rst_outs", 0, 0, 0);
    step(2);
    reset = 1'b0;
    step(20);
    check_eq("f_after_floor", int'(floor), 0);
    check_outs("f_after_outs", 0, 0, 0);
    check_eq("f_after_req", int'(dut.requests), 0);

    check_eq("onehot", onehot_err, 0);
    check_eq("debug", dbg_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
